downsample_engine: RTL and testbench

DOWNSAMPLE_ENGINE -- requirements
Module: downsample_engine

---
 rtl/downsample_pkg.sv | 28 ++
 rtl/downsample_addr_gen.sv | 101 ++++++++++
 rtl/downsample_engine.sv | 171 +++++++++++++++++
 tb/tb_downsample_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/downsample_pkg.sv
// Shared definitions for the downsample engine.
//   state_t    : frame sequencer states
//   MODE_AVG   : box-average each FACTOR x FACTOR block
//   MODE_DEC   : keep the top-left pixel of each block
//   log2_ceil  : ceiling log2 usable in parameter/localparam expressions
package downsample_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WRITE,
        DONE
    } state_t;

    localparam logic MODE_AVG = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int log2_ceil(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/downsample_addr_gen.sv
// Block / intra-block / output counters and DRAM address arithmetic.
// Ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   clear                : zero every counter (start of frame)
//   pix_adv              : step to the next pixel inside the current block
//   blk_adv              : step to the next block, restart intra-block scan
//   dec_mode             : decimate mode, block is a single (top-left) pixel
//   src_addr, dst_addr   : current source read / destination write address
//   last_pixel_in_block  : current pixel is the last one read for this block
//   last_block           : current block is the last block of the frame
module downsample_addr_gen
    import downsample_pkg::*;
#(
    parameter int                IMG_WIDTH  = 16,
    parameter int                IMG_HEIGHT = 16,
    parameter int                FACTOR     = 2,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] SRC_BASE   = '0,
    parameter logic [ADDR_W-1:0] DST_BASE   = ADDR_W'(32'h8000)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              pix_adv,
    input  logic              blk_adv,
    input  logic              dec_mode,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              last_pixel_in_block,
    output logic              last_block
);

    localparam int LOG2F = log2_ceil(FACTOR);
    localparam int BLK_X = IMG_WIDTH / FACTOR;
    localparam int BLK_Y = IMG_HEIGHT / FACTOR;
    localparam int PW    = (LOG2F > 0) ? LOG2F : 1;
    localparam int BXW   = (log2_ceil(BLK_X) > 0) ? log2_ceil(BLK_X) : 1;
    localparam int BYW   = (log2_ceil(BLK_Y) > 0) ? log2_ceil(BLK_Y) : 1;

    localparam logic [PW-1:0]  P_LAST  = PW'(FACTOR - 1);
    localparam logic [BXW-1:0] BX_LAST = BXW'(BLK_X - 1);
    localparam logic [BYW-1:0] BY_LAST = BYW'(BLK_Y - 1);

    localparam logic [31:0] F32   = 32'(FACTOR);
    localparam logic [31:0] W32   = 32'(IMG_WIDTH);
    localparam logic [31:0] OW32  = 32'(BLK_X);
    localparam logic [31:0] SRC32 = 32'(SRC_BASE);
    localparam logic [31:0] DST32 = 32'(DST_BASE);

    logic [PW-1:0]  px, py;
    logic [BXW-1:0] bx;
    logic [BYW-1:0] by;

    logic [31:0] row, col, src_full, dst_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            px <= '0;
            py <= '0;
            bx <= '0;
            by <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
            bx <= '0;
            by <= '0;
        end else if (blk_adv) begin
            px <= '0;
            py <= '0;
            if (bx == BX_LAST) begin
                bx <= '0;
                by <= by + 1'b1;
            end else begin
                bx <= bx + 1'b1;
            end
        end else if (pix_adv) begin
            if (px == P_LAST) begin
                px <= '0;
                py <= py + 1'b1;
            end else begin
                px <= px + 1'b1;
            end
        end
    end

    // Decimation reads only the first pixel, so that pixel closes the block.
    assign last_pixel_in_block = dec_mode | ((px == P_LAST) && (py == P_LAST));
    assign last_block          = (bx == BX_LAST) && (by == BY_LAST);

    // 32-bit intermediates, truncated to ADDR_W so bases near the top wrap.
    always_comb begin
        row      = 32'(by) * F32 + 32'(py);
        col      = 32'(bx) * F32 + 32'(px);
        src_full = SRC32 + row * W32 + col;
        dst_full = DST32 + 32'(by) * OW32 + 32'(bx);
    end

    assign src_addr = src_full[ADDR_W-1:0];
    assign dst_addr = dst_full[ADDR_W-1:0];

endmodule

// File: rtl/downsample_engine.sv
// Image downsampler: reads a source frame from DRAM block by block and
// writes one output pixel per FACTOR x FACTOR block (box average or
// top-left decimation).
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   start, mode         : begin a frame; 0 = average, 1 = decimate
//   busy, done          : frame in progress / one-cycle completion pulse
//   DRAM_address        : read or write address
//   DRAM_input_data     : read data, valid the cycle after its address
//   DRAM_output_data    : write data
//   write_DRAM          : write strobe, one cycle per output pixel
//
// state   | meaning
// IDLE    | waiting for start
// RD_ADDR | source address of the current pixel on the bus
// RD_DATA | read data returned, folded into the accumulator
// WRITE   | one output pixel written, accumulator cleared
// DONE    | frame finished, done/busy update on the next edge
module downsample_engine
    import downsample_pkg::*;
#(
    parameter int                IMG_WIDTH  = 16,
    parameter int                IMG_HEIGHT = 16,
    parameter int                FACTOR     = 2,
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] SRC_BASE   = '0,
    parameter logic [ADDR_W-1:0] DST_BASE   = ADDR_W'(32'h8000)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] DRAM_address,
    input  logic [DATA_W-1:0] DRAM_input_data,
    output logic [DATA_W-1:0] DRAM_output_data,
    output logic              write_DRAM
);

    if (IMG_WIDTH % FACTOR != 0) begin : g_bad_width
        $error("IMG_WIDTH must be a multiple of FACTOR");
    end
    if (IMG_HEIGHT % FACTOR != 0) begin : g_bad_height
        $error("IMG_HEIGHT must be a multiple of FACTOR");
    end
    if (FACTOR != 1 && FACTOR != 2 && FACTOR != 4 && FACTOR != 8) begin : g_bad_factor
        $error("FACTOR must be 1, 2, 4 or 8");
    end
    if (ADDR_W > 32) begin : g_bad_addr_w
        $error("ADDR_W must not exceed 32");
    end

    localparam int LOG2F = log2_ceil(FACTOR);
    localparam int SHIFT = 2 * LOG2F;
    localparam int ACC_W = DATA_W + SHIFT;

    state_t             state, state_nxt;
    logic               mode_q;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_avg;
    logic               clear, pix_adv, blk_adv;
    logic [ADDR_W-1:0]  src_addr, dst_addr;
    logic               last_pixel_in_block, last_block;

    downsample_addr_gen #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .FACTOR     (FACTOR),
        .ADDR_W     (ADDR_W),
        .SRC_BASE   (SRC_BASE),
        .DST_BASE   (DST_BASE)
    ) u_addr_gen (
        .clock               (clock),
        .reset_n             (reset_n),
        .clear               (clear),
        .pix_adv             (pix_adv),
        .blk_adv             (blk_adv),
        .dec_mode            (mode_q),
        .src_addr            (src_addr),
        .dst_addr            (dst_addr),
        .last_pixel_in_block (last_pixel_in_block),
        .last_block          (last_block)
    );

    assign acc_avg = acc >> SHIFT;

    always_comb begin
        state_nxt        = state;
        clear            = 1'b0;
        pix_adv          = 1'b0;
        blk_adv          = 1'b0;
        DRAM_address     = '0;
        DRAM_output_data = '0;
        write_DRAM       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = RD_ADDR;
                end
            end
            RD_ADDR: begin
                DRAM_address = src_addr;
                state_nxt    = RD_DATA;
            end
            RD_DATA: begin
                DRAM_address = src_addr;
                if (last_pixel_in_block) begin
                    state_nxt = WRITE;
                end else begin
                    pix_adv   = 1'b1;
                    state_nxt = RD_ADDR;
                end
            end
            WRITE: begin
                DRAM_address     = dst_addr;
                write_DRAM       = 1'b1;
                DRAM_output_data = (mode_q == MODE_DEC) ? acc[DATA_W-1:0]
                                                        : acc_avg[DATA_W-1:0];
                if (last_block) begin
                    state_nxt = DONE;
                end else begin
                    blk_adv   = 1'b1;
                    state_nxt = RD_ADDR;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // busy follows the next state so it rises right after the start edge;
    // done is registered off DONE so it lands together with busy falling.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mode_q <= MODE_AVG;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        acc    <= '0;
                    end
                end
                RD_DATA: begin
                    acc <= (mode_q == MODE_DEC) ? ACC_W'(DRAM_input_data)
                                                : acc + ACC_W'(DRAM_input_data);
                end
                WRITE: begin
                    acc <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_downsample_engine.sv
module tb_downsample_engine;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        int              mode;
        int              pat;
        logic [3:0][7:0] exp_out;
        int              exp_lat;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic        mode;
    logic        start_v [4];
    logic        busy_v  [4];
    logic        done_v  [4];
    logic        wr_v    [4];
    logic [15:0] addr_v  [4];
    logic [7:0]  dout_v  [4];
    logic [7:0]  rdata_v [4];

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_tr [0:255];
    int          img [0:255];
    int          exp_q [$];
    wr_t         wq [$];

    int cfg_w    [4] = '{4, 8, 4, 4};
    int cfg_f    [4] = '{2, 4, 1, 2};
    int cfg_base [4] = '{0, 0, 0, 32'hFFFE};

    int n_pass  = 0;
    int n_total = 0;

    downsample_engine #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .FACTOR(2)) u_a (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .mode(mode),
        .busy(busy_v[0]), .done(done_v[0]), .DRAM_address(addr_v[0]),
        .DRAM_input_data(rdata_v[0]), .DRAM_output_data(dout_v[0]), .write_DRAM(wr_v[0]));

    downsample_engine #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .FACTOR(4)) u_b (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .mode(mode),
        .busy(busy_v[1]), .done(done_v[1]), .DRAM_address(addr_v[1]),
        .DRAM_input_data(rdata_v[1]), .DRAM_output_data(dout_v[1]), .write_DRAM(wr_v[1]));

    downsample_engine #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .FACTOR(1)) u_c (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .mode(mode),
        .busy(busy_v[2]), .done(done_v[2]), .DRAM_address(addr_v[2]),
        .DRAM_input_data(rdata_v[2]), .DRAM_output_data(dout_v[2]), .write_DRAM(wr_v[2]));

    downsample_engine #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .FACTOR(2), .SRC_BASE(16'hFFFE)) u_d (
        .clock(clock), .reset_n(reset_n), .start(start_v[3]), .mode(mode),
        .busy(busy_v[3]), .done(done_v[3]), .DRAM_address(addr_v[3]),
        .DRAM_input_data(rdata_v[3]), .DRAM_output_data(dout_v[3]), .write_DRAM(wr_v[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DRAM: read data appears the cycle after the address.
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) rdata_v[i] <= mem[addr_v[i]];
    end

    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_v[i]) wq.push_back('{i, addr_v[i], dout_v[i]});
        end
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic load_img(input int id);
        int w;
        w = cfg_w[id];
        for (int i = 0; i < w * w; i++) mem[(cfg_base[id] + i) & 32'hFFFF] = 8'(img[i]);
    endtask

    // Expected output pixels straight from the block definition.
    task automatic ref_frame(input int w, input int f, input int m);
        exp_q.delete();
        for (int by = 0; by < w / f; by++) begin
            for (int bx = 0; bx < w / f; bx++) begin
                if (m != 0) begin
                    exp_q.push_back(img[by * f * w + bx * f]);
                end else begin
                    int s;
                    s = 0;
                    for (int dy = 0; dy < f; dy++)
                        for (int dx = 0; dx < f; dx++)
                            s += img[(by * f + dy) * w + bx * f + dx];
                    exp_q.push_back(s / (f * f));
                end
            end
        end
    endtask

    task automatic check_writes(input string name, input int id);
        chk($sformatf("%s_nwr", name), wq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
            chk($sformatf("%s_id%0d", name, i), wq[i].id, id);
            chk($sformatf("%s_addr%0d", name, i), wq[i].a, 32'h8000 + i);
            chk($sformatf("%s_data%0d", name, i), wq[i].d, exp_q[i]);
        end
    endtask

    // One frame on DUT id; start re-pulsed at cycles p1/p2, mode flipped mid-frame.
    task automatic run_frame(input int id, input int m, input int p1, input int p2,
                             input string name, output int lat);
        int w, f, r, exp_lat;
        bit busy_ok, x_ok;
        w = cfg_w[id];
        f = cfg_f[id];
        r = (m == 0) ? f * f : 1;
        exp_lat = (w / f) * (w / f) * (2 * r + 1) + 1;
        wq.delete();
        busy_ok = 1'b1;
        x_ok = 1'b1;
        lat = -1;
        mode = m[0];
        start_v[id] = 1'b1;
        @(posedge clock); #1;
        start_v[id] = 1'b0;
        addr_tr[0] = addr_v[id];
        if (busy_v[id] !== 1'b1) busy_ok = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            @(posedge clock); #1;
            start_v[id] = (k == p1 || k == p2);
            if (k == 2) mode = ~m[0];
            if (k < 256) addr_tr[k] = addr_v[id];
            if ($isunknown({busy_v[id], done_v[id], wr_v[id], addr_v[id], dout_v[id]})) x_ok = 1'b0;
            if (done_v[id]) begin
                lat = k;
                if (busy_v[id]) busy_ok = 1'b0;
                break;
            end
            if (!busy_v[id]) busy_ok = 1'b0;
        end
        start_v[id] = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (busy_v[id] || done_v[id]) busy_ok = 1'b0;
        end
        chk($sformatf("%s_latency", name), lat, exp_lat);
        chk($sformatf("%s_busy_shape", name), busy_ok, 1);
        chk($sformatf("%s_no_x", name), x_ok, 1);
        ref_frame(w, f, m);
        check_writes(name, id);
    endtask

    vec_t vecs [4];

    initial begin
        int lat;
        vecs[0] = '{0, 0, {8'd12, 8'd10, 8'd4, 8'd2}, 37};
        vecs[1] = '{1, 0, {8'd10, 8'd8,  8'd2, 8'd0}, 13};
        vecs[2] = '{0, 1, {8'd0,  8'd0,  8'd0, 8'd1}, 37};
        vecs[3] = '{1, 1, {8'd0,  8'd0,  8'd0, 8'd1}, 13};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        mode = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        chk("rst_wr", wr_v[0], 0);
        chk("rst_addr", addr_v[0], 0);
        chk("rst_dout", dout_v[0], 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("idle_addr", addr_v[0], 0);
        chk("idle_busy", busy_v[0], 0);

        // Table-driven 4x4, FACTOR=2 vectors.
        foreach (vecs[v]) begin
            for (int i = 0; i < 16; i++) img[i] = (vecs[v].pat == 0) ? i : 0;
            if (vecs[v].pat == 1) begin
                img[0] = 1; img[1] = 1; img[4] = 1; img[5] = 2;
            end
            load_img(0);
            run_frame(0, vecs[v].mode, -1, -1, $sformatf("vec%0d", v), lat);
            chk($sformatf("vec%0d_tbl_lat", v), lat, vecs[v].exp_lat);
            for (int j = 0; j < 4; j++) begin
                if (j < wq.size()) chk($sformatf("vec%0d_tbl_out%0d", v, j), wq[j].d, vecs[v].exp_out[j]);
                else chk($sformatf("vec%0d_tbl_missing%0d", v, j), wq.size(), j + 1);
            end
        end

        // start re-pulsed mid-frame and during the DONE cycle.
        for (int i = 0; i < 16; i++) img[i] = i;
        load_img(0);
        run_frame(0, 0, 5, 36, "busy_start", lat);

        // All-0xFF 8x8 at FACTOR=4: sum must not overflow.
        for (int i = 0; i < 64; i++) img[i] = 255;
        load_img(1);
        run_frame(1, 0, -1, -1, "ff_f4", lat);
        if (wq.size() > 0) chk("ff_f4_first", wq[0].d, 8'hFF);
        else chk("ff_f4_first_missing", wq.size(), 1);

        // Source base near the top of the address space.
        for (int i = 0; i < 16; i++) img[i] = 16 * i + 3;
        load_img(3);
        run_frame(3, 0, -1, -1, "wrap", lat);
        chk("wrap_a0", addr_tr[0], 16'hFFFE);
        chk("wrap_a2", addr_tr[2], 16'hFFFF);
        chk("wrap_a4", addr_tr[4], 16'h0002);
        chk("wrap_a8", addr_tr[8], 16'h8000);
        chk("wrap_a9", addr_tr[9], 16'h0000);

        // Reset during the third block's RD_DATA.
        for (int i = 0; i < 16; i++) img[i] = i;
        load_img(0);
        wq.delete();
        mode = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clock); #1;
        start_v[0] = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        chk("abort_pre_addr", addr_v[0], 16'd8);
        reset_n = 1'b0;
        #1;
        chk("abort_wr", wr_v[0], 0);
        chk("abort_busy", busy_v[0], 0);
        chk("abort_done", done_v[0], 0);
        chk("abort_addr", addr_v[0], 0);
        chk("abort_dout", dout_v[0], 0);
        chk("abort_nwr", wq.size(), 2);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("abort_post_nwr", wq.size(), 2);
        chk("abort_post_busy", busy_v[0], 0);
        run_frame(0, 0, -1, -1, "after_rst", lat);

        // Randomized frames on every configuration.
        for (int t = 0; t < 12; t++) begin
            int id, m;
            id = t % 4;
            m = int'($urandom_range(0, 1));
            for (int i = 0; i < cfg_w[id] * cfg_w[id]; i++) img[i] = int'($urandom_range(0, 255));
            load_img(id);
            run_frame(id, m, -1, -1, $sformatf("rnd%0d", t), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
